poly_root_finder: RTL and testbench
===================================

Name: poly_root_finder

Overview:
- Inverse companion to the quadratic evaluator. Loads coefficients A, B, C and a target Y through the same press/release `go` handshake.
- Exhaustively searches x = 0..2^WIDTH-1 for the smallest x with A*x^2 + B*x + C ≡ Y (mod 2^WIDTH).
- Uses a multi-cycle Horner datapath under FSM control and reports the root on board-level outputs (LEDR/HEX wrapper).

Parameters:
- WIDTH, 8, operand and arithmetic width; all arithmetic is modulo 2^WIDTH.

Ports:
- clk  in  1  system clock
- resetn  in  1  reset, synchronous, active-low
- go  in  1  active-high advance strobe (debounced, inverted KEY)
- data_in  in  WIDTH  operand value sampled during load states
- x_out  out  WIDTH  smallest root found; 0 if none
- found  out  1  at least one root exists
- done  out  1  search complete, result valid
- busy  out  1  search in progress
- root_count  out  WIDTH+1  number of roots (feature-dependent, see below)

Behaviour:
- Reset, when resetn=0 at a clk edge:
  - State goes to LOAD_A.
  - A, B, C, Y, x, t, x_out, found, done, busy and root_count all go to 0.
  - Reset has priority in every state, including mid-search; no partial result is retained.
- Load FSM (A shown; B, C and Y identical):
  - LOAD_A: A <= data_in every cycle. go=1 -> LOAD_A_WAIT.
  - LOAD_A_WAIT: go=1 stays; go=0 -> LOAD_B.
  - Order: LOAD_A, LOAD_B, LOAD_C, LOAD_Y.
  - The value captured is data_in in the last LOAD_k cycle before go rises.
- LOAD_Y_WAIT with go=0 -> EVAL_0. On that same edge:
  - x <= 0.
  - x_out, found, done and root_count are cleared.
  - busy <= 1.
- Per-candidate evaluation, 5 cycles:
  - EVAL_0: t <= A*x (product truncated to WIDTH).
  - EVAL_1: t <= t + B.
  - EVAL_2: t <= t*x (truncated).
  - EVAL_3: t <= t + C.
  - CHECK: compare t with Y.
    - Match: found <= 1 and x_out <= x, then -> DONE.
    - No match with x = 2^WIDTH-1: -> DONE with found=0, x_out=0.
    - Otherwise: x <= x+1, -> EVAL_0.
- Timing:
  - Cycle 0 is the first EVAL_0. Candidate k is checked at cycle 5k+4; DONE is entered at 5k+5.
  - Worst case: DONE at cycle 5*2^WIDTH (1280 for WIDTH=8).
- Wrap-around:
  - x never wraps. Candidate 2^WIDTH-1 is evaluated exactly once and is the last.
- DONE / DONE_WAIT:
  - On DONE entry: busy <= 0, done <= 1.
  - DONE: go=1 -> DONE_WAIT.
  - DONE_WAIT: go=0 -> LOAD_A, done <= 0.
  - x_out, found and root_count hold until the next search start or reset.
  - go during the search is ignored.
- Outputs are registered, with no combinational path from inputs to outputs.

Optional Feature:
- Macro: POLY_ROOT_FINDER_COUNT_EN.
- Defined:
  - CHECK does not stop on a match. Every candidate 0..2^WIDTH-1 is evaluated.
  - root_count increments on each match.
  - x_out latches the first match only; found = (root_count != 0).
  - DONE is always entered at cycle 5*2^WIDTH; a full 256-root count is representable in WIDTH+1 bits.
- Undefined:
  - Stops at the first match.
  - root_count equals found (0 or 1), zero-extended.

Test Plan:
- A=0, B=3, C=5, Y=20 loaded via four go press/release pairs -> x_out=5, found=1, done rises at cycle 30, busy=1 during cycles 0..29.
- A=1, B=0, C=0, Y=1, macro undefined -> x_out=1, found=1, root_count=1, done at cycle 10. Macro defined -> x_out=1, root_count=4 (roots 1, 127, 129, 255), done at cycle 1280.
- A=0, B=0, C=1, Y=2 -> no root: found=0, x_out=0, root_count=0, done at cycle 1280.
- A=1, B=0, C=0, Y=0 with macro defined -> root_count=16 (multiples of 16), x_out=0. Macro undefined -> x_out=0, done at cycle 5.
- Holding go high across several cycles in every WAIT state, then toggling go during the search -> values captured exactly once, search result unaffected, DONE->LOAD_A only after a full press and release.
- resetn=0 for one cycle at search cycle 40 -> all outputs 0, state LOAD_A. A fresh load of A=0, B=1, C=0, Y=7 then yields x_out=7, done at cycle 40.

Source files
------------

// File: rtl/poly_root_finder.sv
// ---------------------------------------------------------------------------
// poly_root_finder
//
// Loads coefficients A, B, C and a target Y through a press/release `go`
// handshake, then searches x = 0 .. 2^WIDTH-1 for the smallest x where
// A*x^2 + B*x + C == Y (mod 2^WIDTH). Each candidate is evaluated with a
// shared Horner datapath over five cycles: t = ((A*x) + B)*x + C.
//
// Optional feature macro: POLY_ROOT_FINDER_COUNT_EN
//   defined   - every candidate is evaluated, root_count counts all roots,
//               x_out keeps the first (smallest) root.
//   undefined - the search stops at the first root; root_count is 0 or 1.
//
// Ports:
//   clk         system clock
//   resetn      synchronous, active-low reset
//   go          active-high advance strobe (press/release)
//   data_in     operand sampled while in a LOAD state
//   x_out       smallest root found, 0 if none
//   found       at least one root exists
//   done        search complete, result valid
//   busy        search in progress
//   root_count  number of roots found (WIDTH+1 bits)
// ---------------------------------------------------------------------------
module poly_root_finder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             go,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] x_out,
    output logic             found,
    output logic             done,
    output logic             busy,
    output logic [WIDTH:0]   root_count
);

    typedef enum logic [3:0] {
        LOAD_A, LOAD_A_WAIT,
        LOAD_B, LOAD_B_WAIT,
        LOAD_C, LOAD_C_WAIT,
        LOAD_Y, LOAD_Y_WAIT,
        EVAL_0, EVAL_1, EVAL_2, EVAL_3,
        CHECK,
        DONE, DONE_WAIT
    } state_t;

    state_t state_reg, state_next;

    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] c_reg, c_next;
    logic [WIDTH-1:0] y_reg, y_next;
    logic [WIDTH-1:0] x_reg, x_next;
    logic [WIDTH-1:0] t_reg, t_next;
    logic [WIDTH-1:0] x_out_reg, x_out_next;
    logic             found_reg, found_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic [WIDTH:0]   root_count_reg, root_count_next;

    logic hit;
    logic last_candidate;

    assign hit            = (t_reg == y_reg);
    // x never wraps: the all-ones candidate is the final one evaluated.
    assign last_candidate = (x_reg == '1);

    always_comb begin
        state_next      = state_reg;
        a_next          = a_reg;
        b_next          = b_reg;
        c_next          = c_reg;
        y_next          = y_reg;
        x_next          = x_reg;
        t_next          = t_reg;
        x_out_next      = x_out_reg;
        found_next      = found_reg;
        done_next       = done_reg;
        busy_next       = busy_reg;
        root_count_next = root_count_reg;

        case (state_reg)
            // Operands track data_in every cycle, so the value held is the
            // one present in the last LOAD cycle before go rises.
            LOAD_A: begin
                a_next = data_in;
                if (go) state_next = LOAD_A_WAIT;
            end
            LOAD_A_WAIT: if (!go) state_next = LOAD_B;
            LOAD_B: begin
                b_next = data_in;
                if (go) state_next = LOAD_B_WAIT;
            end
            LOAD_B_WAIT: if (!go) state_next = LOAD_C;
            LOAD_C: begin
                c_next = data_in;
                if (go) state_next = LOAD_C_WAIT;
            end
            LOAD_C_WAIT: if (!go) state_next = LOAD_Y;
            LOAD_Y: begin
                y_next = data_in;
                if (go) state_next = LOAD_Y_WAIT;
            end
            LOAD_Y_WAIT: begin
                if (!go) begin
                    state_next      = EVAL_0;
                    x_next          = '0;
                    x_out_next      = '0;
                    found_next      = 1'b0;
                    done_next       = 1'b0;
                    root_count_next = '0;
                    busy_next       = 1'b1;
                end
            end
            EVAL_0: begin
                t_next     = a_reg * x_reg;
                state_next = EVAL_1;
            end
            EVAL_1: begin
                t_next     = t_reg + b_reg;
                state_next = EVAL_2;
            end
            EVAL_2: begin
                t_next     = t_reg * x_reg;
                state_next = EVAL_3;
            end
            EVAL_3: begin
                t_next     = t_reg + c_reg;
                state_next = CHECK;
            end
            CHECK: begin
`ifdef POLY_ROOT_FINDER_COUNT_EN
                if (hit) begin
                    found_next      = 1'b1;
                    root_count_next = root_count_reg + (WIDTH+1)'(1);
                    // Only the first (smallest) root is reported.
                    if (root_count_reg == '0) x_out_next = x_reg;
                end
                if (last_candidate) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    x_next     = x_reg + WIDTH'(1);
                    state_next = EVAL_0;
                end
`else
                if (hit) begin
                    found_next      = 1'b1;
                    x_out_next      = x_reg;
                    root_count_next = (WIDTH+1)'(1);
                    state_next      = DONE;
                    busy_next       = 1'b0;
                    done_next       = 1'b1;
                end else if (last_candidate) begin
                    state_next = DONE;
                    busy_next  = 1'b0;
                    done_next  = 1'b1;
                end else begin
                    x_next     = x_reg + WIDTH'(1);
                    state_next = EVAL_0;
                end
`endif
            end
            DONE: if (go) state_next = DONE_WAIT;
            DONE_WAIT: begin
                if (!go) begin
                    state_next = LOAD_A;
                    done_next  = 1'b0;
                end
            end
            default: state_next = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg      <= LOAD_A;
            a_reg          <= '0;
            b_reg          <= '0;
            c_reg          <= '0;
            y_reg          <= '0;
            x_reg          <= '0;
            t_reg          <= '0;
            x_out_reg      <= '0;
            found_reg      <= 1'b0;
            done_reg       <= 1'b0;
            busy_reg       <= 1'b0;
            root_count_reg <= '0;
        end else begin
            state_reg      <= state_next;
            a_reg          <= a_next;
            b_reg          <= b_next;
            c_reg          <= c_next;
            y_reg          <= y_next;
            x_reg          <= x_next;
            t_reg          <= t_next;
            x_out_reg      <= x_out_next;
            found_reg      <= found_next;
            done_reg       <= done_next;
            busy_reg       <= busy_next;
            root_count_reg <= root_count_next;
        end
    end

    assign x_out      = x_out_reg;
    assign found      = found_reg;
    assign done       = done_reg;
    assign busy       = busy_reg;
    assign root_count = root_count_reg;

endmodule

// File: tb/tb_poly_root_finder.sv
// ---------------------------------------------------------------------------
// tb_poly_root_finder
//
// Directed bench for poly_root_finder (WIDTH=8). Loads operands through the
// go press/release handshake, measures the search length in cycles from the
// first EVAL_0 and checks the reported root, found flag and root count.
// Expected values follow the build: POLY_ROOT_FINDER_COUNT_EN selects the
// counting variant's results.
// ---------------------------------------------------------------------------
module tb_poly_root_finder;

`ifdef POLY_ROOT_FINDER_COUNT_EN
    localparam bit CNT = 1'b1;
`else
    localparam bit CNT = 1'b0;
`endif
    localparam int FULL = 1280;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       go = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] x_out;
    logic       found;
    logic       done;
    logic       busy;
    logic [8:0] root_count;

    int tests = 0;
    int fails = 0;

    poly_root_finder #(.WIDTH(8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .go         (go),
        .data_in    (data_in),
        .x_out      (x_out),
        .found      (found),
        .done       (done),
        .busy       (busy),
        .root_count (root_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Direct polynomial evaluation (not Horner) to count roots.
    function automatic int ref_count(input int a, input int b, input int c, input int y);
        int n = 0;
        for (int x = 0; x < 256; x++)
            if (((a * x * x + b * x + c) & 255) == y) n++;
        return n;
    endfunction

    // One press/release; data_in is scrambled once go is high so only the
    // value present before the press can be captured.
    task automatic press(input logic [7:0] v, input int hold);
        data_in = v;
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        data_in = ~v;
        repeat (hold - 1) @(negedge clk);
        go = 1'b0;
        @(negedge clk);
    endtask

    task automatic load4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] y, input int hold);
        press(a, hold);
        press(b, hold);
        press(c, hold);
        press(y, hold);
    endtask

    // Called in cycle 0 (first EVAL_0); counts edges until done shows.
    task automatic run(input string tag, input int exp_cyc, input bit toggle);
        int  cyc = 0;
        bit  busy_ok = 1'b1;
        check({tag, "_start_clear"}, {done, found, x_out}, 32'd0);
        while (done !== 1'b1 && cyc < 1400) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (toggle) go = ~go;
            @(negedge clk);
            cyc++;
        end
        go = 1'b0;
        check({tag, "_busy_during"}, busy_ok, 1);
        check({tag, "_done_cycle"}, cyc, exp_cyc);
        check({tag, "_busy_after"}, busy, 0);
    endtask

    task automatic results(input string tag, input int ex, input int ef, input int erc);
        check({tag, "_x_out"}, x_out, ex);
        check({tag, "_found"}, found, ef);
        check({tag, "_root_count"}, root_count, erc);
    endtask

    // Full acknowledge: done must survive a held press and drop on release,
    // while the result holds.
    task automatic ack(input string tag, input int ex, input int ef);
        go = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, "_done_held"}, done, 1);
        go = 1'b0;
        @(negedge clk);
        check({tag, "_done_cleared"}, done, 0);
        check({tag, "_x_out_hold"}, x_out, ex);
        check({tag, "_found_hold"}, found, ef);
    endtask

    initial begin
        // Reset state
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_x_out", x_out, 0);
        check("rst_found", found, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_root_count", root_count, 0);
        resetn = 1'b1;
        @(negedge clk);

        // 3x + 5 = 20 -> x = 5 (3 is invertible: unique root)
        load4(8'd0, 8'd3, 8'd5, 8'd20, 1);
        run("lin", CNT ? FULL : 30, 1'b0);
        results("lin", 5, 1, 1);
        ack("lin", 5, 1);

        // x^2 = 1 -> roots 1, 127, 129, 255
        load4(8'd1, 8'd0, 8'd0, 8'd1, 1);
        run("sq1", CNT ? FULL : 10, 1'b0);
        results("sq1", 1, 1, CNT ? 4 : 1);
        ack("sq1", 1, 1);

        // constant 1 never equals 2 -> no root
        load4(8'd0, 8'd0, 8'd1, 8'd2, 1);
        run("none", FULL, 1'b0);
        results("none", 0, 0, 0);
        ack("none", 0, 0);

        // x^2 = 0 -> multiples of 16, first root 0
        load4(8'd1, 8'd0, 8'd0, 8'd0, 1);
        run("sq0", CNT ? FULL : 5, 1'b0);
        results("sq0", 0, 1, CNT ? 16 : 1);
        ack("sq0", 0, 1);

        // 2x^2 + x + 3 = 39 -> first root 4; held go in every WAIT state
        // and go toggling throughout the search
        load4(8'd2, 8'd1, 8'd3, 8'd39, 4);
        run("hold", CNT ? FULL : 25, 1'b1);
        results("hold", 4, 1, CNT ? ref_count(2, 1, 3, 39) : 1);
        ack("hold", 4, 1);

        // Reset in search cycle 40, then a fresh load x = 7
        load4(8'd0, 8'd0, 8'd1, 8'd2, 1);
        repeat (40) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        check("midrst_outputs", {x_out, found, done, busy, root_count}, 0);
        load4(8'd0, 8'd1, 8'd0, 8'd7, 1);
        run("after_rst", CNT ? FULL : 40, 1'b0);
        results("after_rst", 7, 1, 1);
        ack("after_rst", 7, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
